// File: rtl/x9_pkg.sv
// Shared X9 definitions: loader state encoding and default geometry.
package x9_pkg;

  localparam int unsigned D_DEFAULT        = 12;
  localparam int unsigned W_DEFAULT        = 9;
  localparam int unsigned LOADER_MAX_WORDS = 2 ** D_DEFAULT;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_ERROR   = 3'd4
  } loader_state_t;

endpackage

// File: rtl/instr_loader_if.sv
// Host-to-loader instruction stream: valid/ready handshake with last-beat marker.
interface instr_loader_if #(
  parameter int unsigned W = 9
);
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/loader_cksum.sv
// Running XOR of written instruction words; only built with INSTR_LOADER_CHECKSUM_EN.
`ifdef INSTR_LOADER_CHECKSUM_EN
module loader_cksum #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] data,
  output logic [W-1:0] acc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc ^ data;
    end
  end

endmodule
`endif

// File: rtl/instr_loader.sv
// Boot-time instruction loader for the X9 core: streams host words into the
// instruction ROM, holds the core in reset meanwhile. Option: INSTR_LOADER_CHECKSUM_EN.
module instr_loader
  import x9_pkg::*;
#(
  parameter int unsigned D = D_DEFAULT,
  parameter int unsigned W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  instr_loader_if.slave  s,
  output logic           im_wr_en,
  output logic [D-1:0]   im_wr_addr,
  output logic [W-1:0]   im_wr_data,
  output logic           core_reset,
  input  logic           core_done,
  output logic           busy,
  output logic [D:0]     loaded_len,
  output logic           run_done,
  output logic           err
);

  localparam logic [D:0] MAX_CNT = {1'b1, {D{1'b0}}};

  loader_state_t state, state_nx;
  logic [D:0]    count;
  logic          accept;
  logic          overflow;
  logic          wr;
  logic          ck_ok;
  logic          load_start;

  assign accept     = s.s_valid && s.s_ready;
  assign overflow   = accept && (count == MAX_CNT);
  assign load_start = start && ((state == ST_IDLE) || (state == ST_ERROR));

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [W-1:0] cksum;

  // The last beat carries the checksum, so it is compared rather than written.
  assign wr    = accept && !overflow && !s.s_last;
  assign ck_ok = (cksum == s.s_data);

  loader_cksum #(.W(W)) u_cksum (
    .clk   (clk),
    .reset (reset),
    .clear (load_start),
    .en    (wr),
    .data  (s.s_data),
    .acc   (cksum)
  );
`else
  assign wr    = accept && !overflow;
  assign ck_ok = 1'b1;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (start) state_nx = ST_LOAD;
      ST_LOAD: begin
        if (overflow)                    state_nx = ST_ERROR;
        else if (accept && s.s_last)     state_nx = ck_ok ? ST_RELEASE : ST_ERROR;
      end
      ST_RELEASE: state_nx = ST_RUN;
      ST_RUN:     if (core_done) state_nx = ST_IDLE;
      ST_ERROR:   if (start) state_nx = ST_LOAD;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they are registered yet
  // change on the same edge as the state itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      s.s_ready  <= 1'b0;
      core_reset <= 1'b1;
      busy       <= 1'b0;
      run_done   <= 1'b0;
    end else begin
      state      <= state_nx;
      s.s_ready  <= (state_nx == ST_LOAD);
      core_reset <= (state_nx != ST_RUN);
      busy       <= (state_nx != ST_IDLE);
      run_done   <= (state == ST_RUN) && core_done;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_wr_en   <= 1'b0;
      im_wr_addr <= '0;
      im_wr_data <= '0;
      count      <= '0;
    end else begin
      im_wr_en <= wr;
      if (wr) begin
        im_wr_addr <= count[D-1:0];
        im_wr_data <= s.s_data;
      end
      if (load_start)  count <= '0;
      else if (wr)     count <= count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err        <= 1'b0;
      loaded_len <= '0;
    end else begin
      if (load_start)
        err <= 1'b0;
      else if ((state == ST_LOAD) && (state_nx == ST_ERROR))
        err <= 1'b1;

      if ((state == ST_IDLE) && start)
        loaded_len <= '0;
      else if ((state == ST_LOAD) && (state_nx == ST_RELEASE))
        loaded_len <= wr ? count + 1'b1 : count;
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader (D=4); checksum cases build with INSTR_LOADER_CHECKSUM_EN.
module tb_instr_loader;
  localparam int unsigned D = 4;
  localparam int unsigned W = 9;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         core_done = 1'b0;
  logic         im_wr_en;
  logic [D-1:0] im_wr_addr;
  logic [W-1:0] im_wr_data;
  logic         core_reset;
  logic         busy;
  logic [D:0]   loaded_len;
  logic         run_done;
  logic         err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [D-1:0] addr;
    logic [W-1:0] data;
  } wr_t;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  instr_loader_if #(.W(W)) bus ();

  instr_loader #(.D(D), .W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .s          (bus),
    .im_wr_en   (im_wr_en),
    .im_wr_addr (im_wr_addr),
    .im_wr_data (im_wr_data),
    .core_reset (core_reset),
    .core_done  (core_done),
    .busy       (busy),
    .loaded_len (loaded_len),
    .run_done   (run_done),
    .err        (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Every memory write is matched in order against the expected queue.
  always @(negedge clk) begin
    wr_t e;
    if (reset && im_wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                 im_wr_addr, im_wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(im_wr_addr), 32'(e.addr));
        check("wr_data", 32'(im_wr_data), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d, input logic l, input logic [D-1:0] a,
                      input logic exp_wr);
    int n;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    n = 0;
    while (!bus.s_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus.s_ready) begin
      check("ready_timeout", 32'(bus.s_ready), 32'd1);
    end else begin
      if (exp_wr) exp_q.push_back('{addr: a, data: d});
      tick();
      check("wr_en_latency", 32'(im_wr_en), 32'(exp_wr));
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick();
  endtask

  task automatic finish_run();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("run_done_pulse", 32'(run_done), 32'd1);
    check("run_busy_low", 32'(busy), 32'd0);
    check("run_core_reset", 32'(core_reset), 32'd1);
    tick();
    check("run_done_once", 32'(run_done), 32'd0);
  endtask

  initial begin
    logic [W-1:0] thr[4];
    thr[0] = 9'h011; thr[1] = 9'h122; thr[2] = 9'h033; thr[3] = 9'h1FF;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;

    #2 reset = 1'b0;
    #1;
    check("rst_s_ready", 32'(bus.s_ready), 32'd0);
    check("rst_wr_en", 32'(im_wr_en), 32'd0);
    check("rst_wr_addr", 32'(im_wr_addr), 32'd0);
    check("rst_wr_data", 32'(im_wr_data), 32'd0);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_loaded_len", 32'(loaded_len), 32'd0);
    check("rst_run_done", 32'(run_done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    tick();

`ifndef INSTR_LOADER_CHECKSUM_EN
    // Basic three-word load
    do_start();
    check("load_ready", 32'(bus.s_ready), 32'd1);
    check("load_busy", 32'(busy), 32'd1);
    send(9'h1A5, 1'b0, 4'd0, 1'b1);
    send(9'h0F0, 1'b0, 4'd1, 1'b1);
    send(9'h003, 1'b1, 4'd2, 1'b1);
    check("basic_len", 32'(loaded_len), 32'd3);
    check("release_core_reset", 32'(core_reset), 32'd1);
    check("release_ready", 32'(bus.s_ready), 32'd0);
    tick();
    check("run_core_reset_low", 32'(core_reset), 32'd0);
    finish_run();

    // Throttled host
    do_start();
    for (int i = 0; i < 4; i++) begin
      send(thr[i], (i == 3), D'(i), 1'b1);
      if (i < 3) begin
        tick();
        check("gap_no_write", 32'(im_wr_en), 32'd0);
      end
    end
    check("thr_len", 32'(loaded_len), 32'd4);
    tick();
    check("thr_core_reset_low", 32'(core_reset), 32'd0);
    finish_run();
`endif

    // Overflow: 16 writes legal, 17th discarded
    do_start();
    for (int i = 0; i < 16; i++) send(W'(i * 7 + 1), 1'b0, D'(i), 1'b1);
    check("full_no_err", 32'(err), 32'd0);
    send(9'h0AA, 1'b0, 4'd0, 1'b0);
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_busy", 32'(busy), 32'd1);
    check("ovf_core_reset", 32'(core_reset), 32'd1);
    check("ovf_ready", 32'(bus.s_ready), 32'd0);
    tick();
    check("err_sticky", 32'(err), 32'd1);
    check("err_core_reset", 32'(core_reset), 32'd1);
    do_start();
    check("err_cleared", 32'(err), 32'd0);
    check("restart_ready", 32'(bus.s_ready), 32'd1);
    apply_reset();

    // Reset mid-load
    do_start();
    send(9'h0AB, 1'b0, 4'd0, 1'b1);
    send(9'h0CD, 1'b0, 4'd1, 1'b1);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("mid_s_ready", 32'(bus.s_ready), 32'd0);
    check("mid_wr_en", 32'(im_wr_en), 32'd0);
    check("mid_wr_addr", 32'(im_wr_addr), 32'd0);
    check("mid_wr_data", 32'(im_wr_data), 32'd0);
    check("mid_core_reset", 32'(core_reset), 32'd1);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_err", 32'(err), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    do_start();
`ifdef INSTR_LOADER_CHECKSUM_EN
    send(9'h055, 1'b0, 4'd0, 1'b1);
    send(9'h055, 1'b1, 4'd0, 1'b0);
`else
    send(9'h055, 1'b1, 4'd0, 1'b1);
`endif
    check("restart_len", 32'(loaded_len), 32'd1);
    tick();
    check("restart_run", 32'(core_reset), 32'd0);
    finish_run();

`ifdef INSTR_LOADER_CHECKSUM_EN
    // Checksum match
    do_start();
    send(9'h101, 1'b0, 4'd0, 1'b1);
    send(9'h010, 1'b0, 4'd1, 1'b1);
    send(9'h111, 1'b1, 4'd0, 1'b0);
    check("ck_len", 32'(loaded_len), 32'd2);
    check("ck_ok_err", 32'(err), 32'd0);
    tick();
    check("ck_run", 32'(core_reset), 32'd0);
    finish_run();

    // Checksum mismatch
    do_start();
    send(9'h101, 1'b0, 4'd0, 1'b1);
    send(9'h010, 1'b0, 4'd1, 1'b1);
    send(9'h110, 1'b1, 4'd0, 1'b0);
    check("ck_bad_err", 32'(err), 32'd1);
    check("ck_bad_core_reset", 32'(core_reset), 32'd1);
    check("ck_bad_ready", 32'(bus.s_ready), 32'd0);

    // Checksum-only load expects zero
    do_start();
    send(9'h000, 1'b1, 4'd0, 1'b0);
    check("ck_only_err", 32'(err), 32'd0);
    check("ck_only_len", 32'(loaded_len), 32'd0);
    tick();
    check("ck_only_run", 32'(core_reset), 32'd0);
    finish_run();
`endif

    repeat (3) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
